// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit for the RV32M op set.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one bit per cycle, then applies sign correction in FIX.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start_i   request, sampled only in IDLE
//   op_i      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a_i       rs1 operand (multiplicand / dividend)
//   b_i       rs2 operand (multiplier / divisor)
//   flush_i   abort an operation in CALC or FIX
//   busy_o    unit is not idle
//   done_o    one-cycle pulse, result_o valid
//   result_o  result, held until the next accepted start
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [W-1:0]    hi_q, lo_q, mcand_q, result_q;
  logic            neg_q, neg_rem_q, done_q;

  logic [W-1:0]    hi_d, lo_d, fix_d;
  logic [W-1:0]    a_mag, b_mag, special_res;
  logic            a_neg, b_neg, is_special;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    return en ? (~x + W'(1)) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
    return en ? (~x + (2*W)'(1)) : x;
  endfunction

  // Operand decode on the request inputs (only used in IDLE).
  always_comb begin
    logic sa, sb, div0, ovf;
    if (op_i[2]) begin
      sa = ~op_i[0];
      sb = ~op_i[0];
    end else begin
      sa = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
      sb = (op_i[1:0] == 2'b01);
    end
    a_neg = sa & a_i[W-1];
    b_neg = sb & b_i[W-1];
    a_mag = neg_w(a_i, a_neg);
    b_mag = neg_w(b_i, b_neg);
    div0  = op_i[2] & (b_i == '0);
    ovf   = op_i[2] & ~op_i[0] & (a_i == MIN_INT) & (b_i == '1);
    is_special  = div0 | ovf;
    special_res = '0;
    if (div0)     special_res = op_i[1] ? a_i : '1;
    else if (ovf) special_res = op_i[1] ? '0 : MIN_INT;
  end

  // One iteration step: shift-add for multiply, restoring step for divide.
  always_comb begin
    logic [W:0] sum, rem_sh, diff;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh = {hi_q, lo_q[W-1]};
    diff   = rem_sh - {1'b0, mcand_q};
    if (op_q[2]) begin
      // diff[W] set means the trial subtraction went negative: restore.
      hi_d = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
      lo_d = {lo_q[W-2:0], ~diff[W]};
    end else begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end

  // Sign correction of the finished magnitude result.
  always_comb begin
    logic [2*W-1:0] prod;
    prod = neg_2w({hi_q, lo_q}, neg_q);
    if (op_q[2])
      fix_d = op_q[1] ? neg_w(hi_q, neg_rem_q) : neg_w(lo_q, neg_q);
    else
      fix_d = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q      <= op_i[2:0];
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= op_i[2] ? a_mag : b_mag;
            mcand_q   <= op_i[2] ? b_mag : a_mag;
            if (is_special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at 32-bit width.
module tb_mul_div_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as_, au, bs, bu, p;
    int sa, sb;
    as_ = {{32{a[31]}}, a};
    au  = {32'h0, a};
    bs  = {{32{b[31]}}, b};
    bu  = {32'h0, b};
    sa  = a;
    sb  = b;
    case (op)
      3'd0: begin p = au * bu;  return p[31:0];  end
      3'd1: begin p = as_ * bs; return p[63:32]; end
      3'd2: begin p = as_ * bu; return p[63:32]; end
      3'd3: begin p = au * bu;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Starts an op at the current negedge, scrambles inputs after acceptance,
  // waits (bounded) for done_o, returns result and latency, ends one cycle later in IDLE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
    lat = 1;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h required 0 0 00000000", busy_o, done_o, result_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] res;
    op_i = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD; start_i = 1'b1;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy_c0: got %b required 0", busy_o); end
    res = '0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      start_i = 1'b0; a_i = 32'h1234_5678;
      n_checks++;
      if (busy_o !== (c <= 34)) begin
        n_fail++; $display("FAIL mul_busy cycle %0d: got %b required %b", c, busy_o, (c <= 34));
      end
      n_checks++;
      if (done_o !== (c == 34)) begin
        n_fail++; $display("FAIL mul_done cycle %0d: got %b required %b", c, done_o, (c == 34));
      end
      if (c == 34) res = result_o;
    end
    n_checks++;
    if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h required ffffffeb", res); end
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
    logic [31:0] as_ [3] = '{MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as_[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i] || lat != 34) begin
        n_fail++; $display("FAIL mulh[%0d]: got %h lat %0d required %h lat 34", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as_ [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as_[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i] || lat != 34) begin
        n_fail++; $display("FAIL div[%0d]: got %h lat %0d required %h lat 34", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as_ [4] = '{32'd5, 32'd5, MIN, MIN};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, MIN, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as_[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i] || lat != 1) begin
        n_fail++; $display("FAIL special[%0d]: got %h lat %0d required %h lat 1", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    logic seen_done;
    run_op(3'd5, 32'd100, 32'd7, res, lat);   // result_o = 14
    op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) seen_done = 1'b1;
    end
    flush_i = 1'b1;                            // cycle 10
    @(negedge clk);                            // cycle 11
    flush_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || seen_done || result_o !== 32'd14) begin
      n_fail++;
      $display("FAIL flush: busy=%b done=%b seen_done=%b result=%h required 0 0 0 0000000e",
               busy_o, done_o, seen_done, result_o);
    end
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, res, lat);   // -100 rem 7 = -2
    n_checks++;
    if (res !== 32'hFFFF_FFFE || lat != 34) begin
      n_fail++; $display("FAIL flush_restart: got %h lat %0d required fffffffe lat 34", res, lat);
    end
  endtask

  task automatic test_flush_start_idle();
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: busy got %b required 0", busy_o); end
  endtask

  task automatic test_done_start_ignored();
    int lat;
    op_i = 3'd7; a_i = 32'd9; b_i = 32'd0; start_i = 1'b1;
    @(negedge clk);                            // cycle 1: DONE, start still high
    lat = 1;
    n_checks++;
    if (done_o !== 1'b1 || result_o !== 32'd9) begin
      n_fail++; $display("FAIL done_hold_result: done=%b result=%h required 1 00000009", done_o, result_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ignored: busy=%b done=%b required 0 0", busy_o, done_o);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat;
    logic seen_done;
    run_op(3'd5, 32'd100, 32'd7, res, lat);   // non-zero result before reset
    op_i = 3'd0; a_i = 32'd5; b_i = 32'd6; start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: busy=%b done=%b result=%h required 0 0 00000000", busy_o, done_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin n_fail++; $display("FAIL async_reset_quiet: activity after reset got 1 required 0"); end
  endtask

  task automatic test_random();
    logic [31:0] vals [5];
    logic [31:0] a, b, res, exp;
    logic [2:0]  op;
    int lat, exp_lat;
    for (int i = 0; i < 150; i++) begin
      vals = '{$urandom, 32'h0, 32'h1, 32'hFFFF_FFFF, MIN};
      a  = (i % 4 == 0) ? vals[$urandom_range(4, 0)] : $urandom;
      b  = (i % 3 == 0) ? vals[$urandom_range(4, 0)] : $urandom;
      op = 3'($urandom_range(7, 0));
      exp = ref_model(op, a, b);
      exp_lat = (op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) ? 1 : 34;
      run_op(op, a, b, res, lat);
      n_checks++;
      if (res !== exp || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d required %h lat %0d",
                 i, op, a, b, res, lat, exp, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_flush_start_idle();
    test_done_start_ignored();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
